// File: rtl/cpu_trace_buffer_if.sv
// Read-side valid/ready port of the CPU trace buffer.
// ENTRY_W must match the entry width the buffer is built with.
interface cpu_trace_buffer_if #(
    parameter int ENTRY_W = 73
);
    logic               rd_valid;
    logic               rd_ready;
    logic [ENTRY_W-1:0] rd_data;

    modport master (output rd_valid, output rd_data, input rd_ready);
    modport slave  (input rd_valid, input rd_data, output rd_ready);
endinterface

// File: rtl/cpu_trace_buffer.sv
// Circular trace capture of the CPU debug taps with PC-match trigger and oldest-first drain.
// Optional feature macro: TRACE_TIMESTAMP_EN prepends a free-running cycle timestamp to each entry.
//
// state   | meaning
// IDLE    | nothing captured, waiting for arm
// ARMED   | capturing every cycle, watching for trigger
// CAPTURE | trigger seen, storing POST_TRIG more entries
// DONE    | capture frozen, draining over rd_if
module cpu_trace_buffer #(
    parameter int PC_W      = 8,
    parameter int DATA_W    = 32,
    parameter int DEPTH     = 16,
    parameter int POST_TRIG = 4,
    parameter int TS_W      = 16
) (
    input  logic              MAX10_CLK1_50,
    input  logic              reset,
    input  logic              arm,
    input  logic              force_trig,
    input  logic [PC_W-1:0]   trig_pc,
    input  logic [PC_W-1:0]   pc,
    input  logic [31:0]       instruction,
    input  logic [DATA_W-1:0] alu_result,
    input  logic              reg_we,
    cpu_trace_buffer_if.master rd_if,
    output logic [1:0]        state,
    output logic              triggered
);
    localparam int AW = $clog2(DEPTH);
`ifdef TRACE_TIMESTAMP_EN
    localparam int ENTRY_W = TS_W + 1 + PC_W + 32 + DATA_W;
`else
    localparam int ENTRY_W = 1 + PC_W + 32 + DATA_W;
`endif
    localparam logic [AW:0]   FULL      = (AW + 1)'(DEPTH);
    localparam logic [AW:0]   ONE_LEFT  = (AW + 1)'(1);
    localparam logic [AW-1:0] POST_LAST = AW'((POST_TRIG > 0) ? POST_TRIG - 1 : 0);

    if (DEPTH < 4 || (DEPTH & (DEPTH - 1)) != 0 || POST_TRIG >= DEPTH || TS_W < 1)
    begin : g_param_check
        $error("cpu_trace_buffer: illegal parameter combination");
    end

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_ARMED   = 2'd1,
        S_CAPTURE = 2'd2,
        S_DONE    = 2'd3
    } state_t;

    state_t             st;
    logic [ENTRY_W-1:0] mem [DEPTH];
    logic [AW-1:0]      wr_ptr, rd_ptr, post_cnt;
    logic [AW-1:0]      wr_ptr_nx, rd_ptr_nx, start_ptr;
    logic [AW:0]        fill, fill_nx, remaining;
    logic [ENTRY_W-1:0] tap_entry;
    logic               hit, we;

`ifdef TRACE_TIMESTAMP_EN
    logic [TS_W-1:0] ts;

    always_ff @(posedge MAX10_CLK1_50 or negedge reset) begin
        if (!reset) ts <= '0;
        else        ts <= ts + 1'b1;
    end

    assign tap_entry = {ts, reg_we, pc, instruction, alu_result};
`else
    assign tap_entry = {reg_we, pc, instruction, alu_result};
`endif

    assign we        = (st == S_ARMED) || (st == S_CAPTURE);
    assign hit       = (pc == trig_pc) || force_trig;
    assign wr_ptr_nx = wr_ptr + 1'b1;
    assign rd_ptr_nx = rd_ptr + 1'b1;
    assign fill_nx   = (fill == FULL) ? fill : fill + 1'b1;
    // Once wrapped, the slot about to be overwritten next holds the oldest entry.
    assign start_ptr = (fill_nx == FULL) ? wr_ptr_nx : '0;
    assign state     = st;

    always_ff @(posedge MAX10_CLK1_50) begin
        if (we) mem[wr_ptr] <= tap_entry;
    end

    always_ff @(posedge MAX10_CLK1_50 or negedge reset) begin
        if (!reset) begin
            st             <= S_IDLE;
            wr_ptr         <= '0;
            rd_ptr         <= '0;
            fill           <= '0;
            post_cnt       <= '0;
            remaining      <= '0;
            rd_if.rd_valid <= 1'b0;
            rd_if.rd_data  <= '0;
            triggered      <= 1'b0;
        end else begin
            case (st)
                S_IDLE: begin
                    if (arm) begin
                        st     <= S_ARMED;
                        wr_ptr <= '0;
                        fill   <= '0;
                    end
                end
                S_ARMED: begin
                    wr_ptr <= wr_ptr_nx;
                    fill   <= fill_nx;
                    if (hit) begin
                        triggered <= 1'b1;
                        post_cnt  <= '0;
                        if (POST_TRIG == 0) begin
                            st        <= S_DONE;
                            rd_ptr    <= start_ptr;
                            remaining <= fill_nx;
                        end else begin
                            st <= S_CAPTURE;
                        end
                    end
                end
                S_CAPTURE: begin
                    wr_ptr   <= wr_ptr_nx;
                    fill     <= fill_nx;
                    post_cnt <= post_cnt + 1'b1;
                    if (post_cnt == POST_LAST) begin
                        st        <= S_DONE;
                        rd_ptr    <= start_ptr;
                        remaining <= fill_nx;
                    end
                end
                S_DONE: begin
                    // First DONE cycle loads the output register; afterwards it is refilled on each handshake.
                    if (!rd_if.rd_valid) begin
                        if (remaining != '0) begin
                            rd_if.rd_valid <= 1'b1;
                            rd_if.rd_data  <= mem[rd_ptr];
                        end else begin
                            st        <= S_IDLE;
                            triggered <= 1'b0;
                        end
                    end else if (rd_if.rd_ready) begin
                        rd_ptr    <= rd_ptr_nx;
                        remaining <= remaining - 1'b1;
                        if (remaining == ONE_LEFT) begin
                            rd_if.rd_valid <= 1'b0;
                            st             <= S_IDLE;
                            triggered      <= 1'b0;
                        end else begin
                            rd_if.rd_data <= mem[rd_ptr_nx];
                        end
                    end
                end
                default: st <= S_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_cpu_trace_buffer.sv
// Scoreboard bench for cpu_trace_buffer: model queue keeps the last DEPTH tap entries captured.
module tb_cpu_trace_buffer;
    localparam int PC_W      = 8;
    localparam int DATA_W    = 32;
    localparam int DEPTH     = 8;
    localparam int POST_TRIG = 2;
    localparam int TS_W      = 16;
    localparam int PW        = 1 + PC_W + 32 + DATA_W;
`ifdef TRACE_TIMESTAMP_EN
    localparam int EW = PW + TS_W;
`else
    localparam int EW = PW;
`endif

    logic              clk = 1'b0;
    logic              reset = 1'b0;
    logic              arm = 1'b0;
    logic              force_trig = 1'b0;
    logic              reg_we = 1'b0;
    logic [PC_W-1:0]   trig_pc = '0;
    logic [PC_W-1:0]   pc = '0;
    logic [31:0]       instruction = '0;
    logic [DATA_W-1:0] alu_result = '0;
    logic [1:0]        state;
    logic              triggered;

    int n_checks = 0;
    int n_fail   = 0;
    logic [PW-1:0] model[$];

    cpu_trace_buffer_if #(.ENTRY_W(EW)) rd_if();

    cpu_trace_buffer #(
        .PC_W(PC_W), .DATA_W(DATA_W), .DEPTH(DEPTH), .POST_TRIG(POST_TRIG), .TS_W(TS_W)
    ) dut (
        .MAX10_CLK1_50(clk),
        .reset        (reset),
        .arm          (arm),
        .force_trig   (force_trig),
        .trig_pc      (trig_pc),
        .pc           (pc),
        .instruction  (instruction),
        .alu_result   (alu_result),
        .reg_we       (reg_we),
        .rd_if        (rd_if),
        .state        (state),
        .triggered    (triggered)
    );

    always #10 clk = ~clk;

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic capture(input logic [PC_W-1:0] start_pc, input logic [PC_W-1:0] tpc,
                           input bit force_first, input int max_cycles);
        bit trig_seen = 1'b0;
        int post = 0;
        model.delete();
        trig_pc = tpc;
        @(negedge clk);
        arm = 1'b1;
        @(negedge clk);
        arm = 1'b0;
        check("armed_state", 128'(state), 128'(1));
        for (int k = 0; k < max_cycles; k++) begin
            pc          = start_pc + PC_W'(k);
            instruction = $urandom;
            alu_result  = $urandom;
            reg_we      = 1'($urandom_range(0, 1));
            force_trig  = force_first && (k == 0);
            model.push_back({reg_we, pc, instruction, alu_result});
            if (model.size() > DEPTH) void'(model.pop_front());
            if (trig_seen) post++;
            else if (pc == tpc || force_trig) trig_seen = 1'b1;
            @(negedge clk);
            if (trig_seen && post == POST_TRIG) break;
        end
        force_trig = 1'b0;
        check("done_state", 128'(state), 128'(3));
        check("done_triggered", 128'(triggered), 128'(1));
    endtask

    task automatic drain(input bit toggle_ready);
        int cyc = 0;
        bit prev_hold = 1'b0;
        bit ready;
        bit have_ts = 1'b0;
        logic [EW-1:0] held = '0;
        logic [PW-1:0] exp;
        logic [TS_W-1:0] prev_ts = '0;
        while (model.size() > 0 && cyc < 200) begin
            if (prev_hold) check("rd_data_stable", 128'(rd_if.rd_data), 128'(held));
            ready = toggle_ready ? (cyc % 2 == 0) : 1'b1;
            rd_if.rd_ready = ready;
            if (rd_if.rd_valid && ready) begin
                exp = model.pop_front();
                check("entry", 128'(rd_if.rd_data[PW-1:0]), 128'(exp));
`ifdef TRACE_TIMESTAMP_EN
                if (have_ts) check("ts_step", 128'(rd_if.rd_data[EW-1 -: TS_W]), 128'(TS_W'(prev_ts + 1'b1)));
                prev_ts = rd_if.rd_data[EW-1 -: TS_W];
                have_ts = 1'b1;
`endif
            end
            prev_hold = rd_if.rd_valid && !ready;
            held      = rd_if.rd_data;
            @(negedge clk);
            cyc++;
        end
        rd_if.rd_ready = 1'b0;
        check("drain_left", 128'(model.size()), 128'(0));
        check("drain_valid_low", 128'(rd_if.rd_valid), 128'(0));
        check("drain_idle", 128'(state), 128'(0));
        check("drain_trig_low", 128'(triggered), 128'(0));
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rd_if.rd_ready = 1'b0;
        #25;
        check("rst_state", 128'(state), 128'(0));
        check("rst_valid", 128'(rd_if.rd_valid), 128'(0));
        check("rst_trig", 128'(triggered), 128'(0));
        check("rst_data", 128'(rd_if.rd_data), 128'(0));
        @(negedge clk);
        reset = 1'b1;

        // asynchronous reset while capturing after a forced trigger
        trig_pc = 8'hFF;
        pc      = 8'h20;
        @(negedge clk);
        arm = 1'b1;
        @(negedge clk);
        arm        = 1'b0;
        force_trig = 1'b1;
        @(negedge clk);
        force_trig = 1'b0;
        check("pre_rst_state", 128'(state), 128'(2));
        check("pre_rst_trig", 128'(triggered), 128'(1));
        #2 reset = 1'b0;
        #1;
        check("async_rst_state", 128'(state), 128'(0));
        check("async_rst_valid", 128'(rd_if.rd_valid), 128'(0));
        check("async_rst_trig", 128'(triggered), 128'(0));
        @(negedge clk);
        reset = 1'b1;

        capture(8'h00, 8'h05, 1'b0, 40);
        drain(1'b0);

        capture(8'h00, 8'h0F, 1'b0, 40);
        drain(1'b0);

        capture(8'h40, 8'hFF, 1'b1, 40);
        drain(1'b0);

        capture(8'h00, 8'h05, 1'b0, 40);
        drain(1'b1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
